bus_slave_ctrl: RTL and testbench

- Slave-side protocol engine for the inter-FPGA parallel bus: the peer end of the bus master.
- Drives REQ_W_1/2, REQ_R_1/2, ACK, S_RDY and ABORT; samples STB, WE, M_RDY and AD.
- Moves 32-bit words between the bus and a local valid/ready stream.
- Sits behind a separate IOB register wrapper. All ports here are core-side logical signals.

---
 rtl/bus_proto_pkg.sv | 36 +++
 rtl/bus_slave_timeout.sv | 26 ++
 rtl/bus_slave_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bus_slave_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_proto_pkg.sv
// Shared definitions for the inter-FPGA parallel bus: FSM state codes,
// command-word field positions and the local request arbitration order.
package bus_proto_pkg;

  localparam int DATA_W   = 32;
  localparam int LEN_LSB  = 0;
  localparam int CHAN_BIT = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_TURN  = 3'd2;
  localparam state_t ST_WDATA = 3'd3;
  localparam state_t ST_RDATA = 3'd4;
  localparam state_t ST_ABRT  = 3'd5;

  // dir_tx = 1: local has data, so the master will read from us
  typedef struct packed {
    logic valid;
    logic dir_tx;
    logic chan;
  } grant_t;

  function automatic grant_t arbitrate(input logic [1:0] tx_req,
                                       input logic [1:0] rx_req);
    grant_t g;
    g = '0;
    if (tx_req[0])      g = '{valid: 1'b1, dir_tx: 1'b1, chan: 1'b0};
    else if (tx_req[1]) g = '{valid: 1'b1, dir_tx: 1'b1, chan: 1'b1};
    else if (rx_req[0]) g = '{valid: 1'b1, dir_tx: 1'b0, chan: 1'b0};
    else if (rx_req[1]) g = '{valid: 1'b1, dir_tx: 1'b0, chan: 1'b1};
    return g;
  endfunction

endpackage

// File: rtl/bus_slave_timeout.sv
// Stall counter: clears on demand, counts while enabled, and flags the
// cycle in which the count would reach LIMIT.
module bus_slave_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  assign o_expire = i_inc && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/bus_slave_ctrl.sv
// Slave-side protocol engine of the parallel bus: requests the master,
// checks its command word and moves words between AD and local streams.
module bus_slave_ctrl
  import bus_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  output logic              req_w_1,
  output logic              req_w_2,
  output logic              req_r_1,
  output logic              req_r_2,
  output logic              ack,
  output logic              s_rdy,
  output logic              abort,
  input  logic              stb,
  input  logic              we,
  input  logic              m_rdy,
  input  logic [DATA_W-1:0] adi,
  output logic [DATA_W-1:0] ado,
  output logic              ad_oe,
  input  logic [1:0]        rx_req,
  input  logic [1:0]        tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              chan,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t           r_state;
  state_t           w_nxt;
  logic             r_dir_tx;
  logic             r_chan;
  logic [CNT_W-1:0] r_wcnt;
  logic [3:0]       r_req;
  logic             r_ack;
  logic             r_done;
  logic             r_abort;
  logic             r_err;

  grant_t           w_grant;
  logic [CNT_W-1:0] w_len;
  logic             w_cmd_ok;
  logic             w_xfer;
  logic             w_last;
  logic             w_local_abort;
  logic             w_expire;
  logic             w_stall_clr;
  logic             w_stall_inc;
  logic             w_ack_now;
  logic             w_done_now;
  logic             w_dir_nxt;
  logic             w_chan_nxt;
  logic [3:0]       w_req_nxt;

  assign w_grant  = arbitrate(tx_req, rx_req);
  assign w_len    = adi[LEN_LSB +: CNT_W];
  // The master's direction must be the mirror of ours: we=1 only when we receive
  assign w_cmd_ok = (adi[CHAN_BIT] == r_chan) && (we == !r_dir_tx);

  assign w_xfer = ((r_state == ST_WDATA) && m_rdy && rx_ready) ||
                  ((r_state == ST_RDATA) && m_rdy && tx_valid);
  assign w_last        = w_xfer && (r_wcnt == CNT_W'(1));
  assign w_local_abort = tx_req[r_chan] & rx_req[r_chan];

  always_comb begin
    w_nxt      = r_state;
    w_ack_now  = 1'b0;
    w_done_now = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant.valid) w_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (stb) begin
          if (w_cmd_ok) begin
            w_ack_now = 1'b1;
            if (w_len == '0) begin
              w_nxt      = ST_IDLE;
              w_done_now = 1'b1;
            end else if (we) begin
              w_nxt = ST_WDATA;
            end else begin
              w_nxt = ST_TURN;
            end
          end else begin
            w_nxt = ST_ABRT;
          end
        end else if (w_local_abort || w_expire) begin
          w_nxt = ST_ABRT;
        end
      end
      ST_TURN: begin
        w_nxt = w_local_abort ? ST_ABRT : ST_RDATA;
      end
      ST_WDATA, ST_RDATA: begin
        // A completing last word wins over any simultaneous abort cause
        if (w_last) begin
          w_nxt      = ST_IDLE;
          w_done_now = 1'b1;
        end else if (w_local_abort || w_expire) begin
          w_nxt = ST_ABRT;
        end
      end
      ST_ABRT: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_stall_clr = (w_nxt != r_state) || w_xfer;
  assign w_stall_inc = ((r_state == ST_REQ) || (r_state == ST_WDATA) ||
                        (r_state == ST_RDATA)) && !w_xfer;

  bus_slave_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk_in),
    .rst      (rst),
    .i_clr    (w_stall_clr),
    .i_inc    (w_stall_inc),
    .o_expire (w_expire)
  );

  assign w_dir_nxt  = (r_state == ST_IDLE) ? w_grant.dir_tx : r_dir_tx;
  assign w_chan_nxt = (r_state == ST_IDLE) ? w_grant.chan   : r_chan;

  // r_req bit order: {req_r_2, req_r_1, req_w_2, req_w_1}
  always_comb begin
    w_req_nxt = '0;
    if (w_nxt == ST_REQ) w_req_nxt[{w_dir_nxt, w_chan_nxt}] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dir_tx <= 1'b0;
      r_chan   <= 1'b0;
      r_wcnt   <= '0;
      r_req    <= '0;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_dir_tx <= w_dir_nxt;
      r_chan   <= w_chan_nxt;
      r_req    <= w_req_nxt;
      r_ack    <= w_ack_now;
      r_done   <= w_done_now;
      r_abort  <= (w_nxt == ST_ABRT);
      r_err    <= (w_nxt == ST_ABRT);
      if (w_ack_now)   r_wcnt <= w_len;
      else if (w_xfer) r_wcnt <= r_wcnt - 1'b1;
    end
  end

  assign req_w_1 = r_req[0];
  assign req_w_2 = r_req[1];
  assign req_r_1 = r_req[2];
  assign req_r_2 = r_req[3];
  assign ack     = r_ack;
  assign done    = r_done;
  assign abort   = r_abort;
  assign err     = r_err;
  assign chan    = r_chan;
  assign busy    = (r_state != ST_IDLE);

  // Bus-facing strobes follow the state register so async reset releases AD at once
  assign ad_oe    = (r_state == ST_RDATA);
  assign ado      = (r_state == ST_RDATA) ? tx_data : '0;
  assign tx_ready = (r_state == ST_RDATA) && m_rdy;
  assign rx_data  = (r_state == ST_WDATA) ? adi : '0;
  assign rx_valid = (r_state == ST_WDATA) && m_rdy && rx_ready;
  assign s_rdy    = ((r_state == ST_WDATA) && rx_ready) ||
                    ((r_state == ST_RDATA) && tx_valid);

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// Directed bench for bus_slave_ctrl: read/write bursts, arbitration,
// command mismatch, local abort, stall timeouts and async reset.
module tb_bus_slave_ctrl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        req_w_1, req_w_2, req_r_1, req_r_2;
  logic        ack, s_rdy, abort;
  logic        stb = 1'b0, we = 1'b0, m_rdy = 1'b0;
  logic [31:0] adi = '0;
  logic [31:0] ado;
  logic        ad_oe;
  logic [1:0]  rx_req = '0, tx_req = '0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, chan, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  bus_slave_ctrl #(.TIMEOUT_CYCLES(1024), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst(rst),
    .req_w_1(req_w_1), .req_w_2(req_w_2), .req_r_1(req_r_1), .req_r_2(req_r_2),
    .ack(ack), .s_rdy(s_rdy), .abort(abort),
    .stb(stb), .we(we), .m_rdy(m_rdy), .adi(adi), .ado(ado), .ad_oe(ad_oe),
    .rx_req(rx_req), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .chan(chan), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [3:0] reqs;
    return {req_r_2, req_r_1, req_w_2, req_w_1};
  endfunction

  logic [31:0] rd_words [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
  logic        rd_vld   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] wr_words [3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
  logic        wr_rdy   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    int n;

    // Reset state
    #2;
    chk("rst_req", {28'd0, reqs()}, 32'd0);
    chk("rst_ad_oe", ad_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {ack, abort, done, err, s_rdy, chan}, 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // Read burst on ch1, 4 words with a 2-cycle tx_valid stall
    tx_req = 2'b01;
    tick;
    tx_req = 2'b00;
    chk("rd_req", {28'd0, reqs()}, 32'b0100);
    chk("rd_chan", chan, 0);
    tick;
    chk("rd_req_held", {28'd0, reqs()}, 32'b0100);
    stb = 1'b1; we = 1'b0; adi = 32'h0000_0004;
    tick;
    stb = 1'b0; adi = '0;
    chk("rd_ack", ack, 1);
    chk("rd_req_clr", {28'd0, reqs()}, 32'd0);
    m_rdy = 1'b1; tx_valid = 1'b1; tx_data = rd_words[0];
    #1;
    chk("rd_turn_oe", ad_oe, 0);
    tick;
    chk("rd_ack_pulse", ack, 0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      tx_valid = rd_vld[i];
      tx_data  = rd_words[k];
      #1;
      chk("rd_oe", ad_oe, 1);
      chk("rd_ado", ado, rd_words[k]);
      chk("rd_srdy", s_rdy, rd_vld[i]);
      chk("rd_nodone", done, 0);
      tick;
      if (rd_vld[i]) k++;
    end
    chk("rd_done", done, 1);
    chk("rd_oe_off", ad_oe, 0);
    chk("rd_idle", busy, 0);
    m_rdy = 1'b0; tx_valid = 1'b0;
    tick;
    chk("rd_done_once", done, 0);

    // Write burst on ch2, 3 words with rx_ready toggling
    rx_req = 2'b10;
    tick;
    rx_req = 2'b00;
    chk("wr_req", {28'd0, reqs()}, 32'b0010);
    chk("wr_chan", chan, 1);
    stb = 1'b1; we = 1'b1; adi = 32'h0001_0003;
    tick;
    stb = 1'b0;
    chk("wr_ack", ack, 1);
    m_rdy = 1'b1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      rx_ready = wr_rdy[i];
      adi      = wr_words[k];
      #1;
      chk("wr_srdy", s_rdy, wr_rdy[i]);
      chk("wr_rxvalid", rx_valid, wr_rdy[i]);
      chk("wr_rxdata", rx_data, wr_words[k]);
      chk("wr_oe", ad_oe, 0);
      tick;
      if (wr_rdy[i]) k++;
    end
    chk("wr_done", done, 1);
    chk("wr_chan_end", chan, 1);
    m_rdy = 1'b0; rx_ready = 1'b0; adi = '0;
    tick;

    // Arbitration: tx_req=11 and rx_req=01 -> ch1 read first, then ch2 read
    tx_req = 2'b11; rx_req = 2'b01;
    tick;
    tx_req = 2'b10; rx_req = 2'b00;
    chk("arb_first", {28'd0, reqs()}, 32'b0100);
    stb = 1'b1; we = 1'b0; adi = 32'h0000_0001;
    tick;
    stb = 1'b0; adi = '0;
    chk("arb_ack", ack, 1);
    m_rdy = 1'b1; tx_valid = 1'b1; tx_data = 32'h5555_AAAA;
    tick;
    chk("arb_ado", ado, 32'h5555_AAAA);
    tick;
    m_rdy = 1'b0; tx_valid = 1'b0;
    chk("arb_done", done, 1);
    chk("arb_noreq", {28'd0, reqs()}, 32'd0);
    tick;
    tx_req = 2'b00;
    chk("arb_second", {28'd0, reqs()}, 32'b1000);
    chk("arb_chan2", chan, 1);
    // Wrong channel bit for ch2 -> abort
    stb = 1'b1; we = 1'b0; adi = 32'h0000_0001;
    tick;
    stb = 1'b0; adi = '0;
    chk("arb_mm_abort", abort, 1);
    tick;

    // Command mismatch: adi[16]=1 while chan=0
    tx_req = 2'b01;
    tick;
    tx_req = 2'b00;
    stb = 1'b1; we = 1'b0; adi = 32'h0001_0002;
    tick;
    stb = 1'b0; adi = '0;
    chk("mm_abort", abort, 1);
    chk("mm_err", err, 1);
    chk("mm_noack", ack, 0);
    chk("mm_req_clr", {28'd0, reqs()}, 32'd0);
    tick;
    chk("mm_abort_1cyc", {abort, err}, 0);
    chk("mm_idle", busy, 0);

    // Local abort: tx_req and rx_req of the granted channel together
    tx_req = 2'b01;
    tick;
    rx_req = 2'b01;
    tick;
    tx_req = 2'b00; rx_req = 2'b00;
    chk("la_abort", abort, 1);
    tick;
    chk("la_idle", busy, 0);

    // Timeout in REQ: no stb
    tx_req = 2'b01;
    tick;
    tx_req = 2'b00;
    n = 0;
    while (!abort && n < 2000) begin
      n++;
      tick;
    end
    chk("to_req_cycles", n, 1024);
    chk("to_req_err", err, 1);
    chk("to_req_clr", {28'd0, reqs()}, 32'd0);
    tick;

    // Timeout in RDATA: len=2, m_rdy held 0
    tx_req = 2'b01;
    tick;
    tx_req = 2'b00;
    stb = 1'b1; we = 1'b0; adi = 32'h0000_0002;
    tick;
    stb = 1'b0; adi = '0;
    tx_valid = 1'b1; m_rdy = 1'b0;
    tick;
    chk("to_rd_oe", ad_oe, 1);
    n = 0;
    while (!abort && n < 2000) begin
      n++;
      tick;
    end
    chk("to_rd_cycles", n, 1024);
    chk("to_rd_oe_drop", ad_oe, 0);
    tx_valid = 1'b0;
    tick;

    // Async reset mid-RDATA
    tx_req = 2'b01;
    tick;
    tx_req = 2'b00;
    stb = 1'b1; we = 1'b0; adi = 32'h0000_0003;
    tick;
    stb = 1'b0; adi = '0;
    m_rdy = 1'b1; tx_valid = 1'b1; tx_data = 32'hDEAD_BEEF;
    tick;
    chk("ar_oe_before", ad_oe, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_oe", ad_oe, 0);
    chk("ar_srdy", s_rdy, 0);
    chk("ar_req", {28'd0, reqs()}, 32'd0);
    chk("ar_busy", busy, 0);
    m_rdy = 1'b0; tx_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    // Fresh 1-word write on ch1
    rx_req = 2'b01;
    tick;
    rx_req = 2'b00;
    chk("fr_req", {28'd0, reqs()}, 32'b0001);
    stb = 1'b1; we = 1'b1; adi = 32'h0000_0001;
    tick;
    stb = 1'b0;
    chk("fr_ack", ack, 1);
    m_rdy = 1'b1; rx_ready = 1'b1; adi = 32'hCAFE_F00D;
    #1;
    chk("fr_rxdata", rx_data, 32'hCAFE_F00D);
    chk("fr_rxvalid", rx_valid, 1);
    tick;
    m_rdy = 1'b0; rx_ready = 1'b0; adi = '0;
    chk("fr_done", done, 1);
    chk("fr_err", err, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
